// File: rtl/run_det_ctrl.sv
// Serial run-length detector: flags N consecutive equal bits of a selected
// polarity (Mealy y), counts matches, and optionally stops after a target count.
module run_det_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       cfg_len,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             x,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned LEN_W  = 3;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [CNT_W-1:0]   tgt_q, tgt_d;
  logic [LEN_W-1:0]   rl_q, rl_d;
  logic               lb_q, lb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [LEN_W-1:0]   n_len;
  logic [LEN_W:0]     rl_inc;
  logic [LEN_W-1:0]   rl_adv;
  logic               mode_ok;
  logic               y_c;
  logic [CNT_W:0]     cnt_inc;
  logic [CNT_W-1:0]   cnt_sat;
  logic               tgt_hit;

  // Run-length tracking and the Mealy detect term
  always_comb begin
    n_len  = (len_q < LEN_W'(2)) ? LEN_W'(2) : len_q;
    rl_inc = {1'b0, rl_q} + (LEN_W+1)'(1);
    rl_adv = LEN_W'(1);
    if ((rl_q != '0) && (x == lb_q)) begin
      rl_adv = (rl_inc >= {1'b0, n_len}) ? n_len : rl_inc[LEN_W-1:0];
    end
    // mode 00 wants x=1, mode 01 wants x=0, mode 1x accepts both
    mode_ok = mode_q[1] | (x ^ mode_q[0]);
    y_c     = (state_q == S_RUN) && (rl_adv == n_len) && mode_ok;
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    cnt_sat = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
    tgt_hit = (tgt_q != '0) && y_c && (cnt_inc == {1'b0, tgt_q});
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    rl_d    = rl_q;
    lb_d    = lb_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          mode_d  = cfg_mode;
          tgt_d   = cfg_target;
          rl_d    = '0;
          lb_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rl_d = rl_adv;
        lb_d = x;
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (y_c) begin
            cnt_d = cnt_sat;
          end
          if (tgt_hit) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      mode_q  <= '0;
      tgt_q   <= '0;
      rl_q    <= '0;
      lb_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      rl_q    <= rl_d;
      lb_q    <= lb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign y         = y_c;
  assign busy      = busy_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_run_det_ctrl.sv
// Directed bench for run_det_ctrl: expected y per bit is queued as each bit is
// driven and popped when the Mealy output is sampled mid-cycle.
module tb_run_det_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [2:0]       cfg_len;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_target;
  logic             x;
  logic             y;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] match_cnt;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  run_det_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_len    (cfg_len),
    .cfg_mode   (cfg_mode),
    .cfg_target (cfg_target),
    .x          (x),
    .y          (y),
    .busy       (busy),
    .done       (done),
    .match_cnt  (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // drive one data bit, check the Mealy output against the queued expectation
  task automatic bit_step(input string tag, input logic xi, input logic ey);
    logic e;
    exp_q.push_back(ey);
    x = xi;
    #1;
    e = exp_q.pop_front();
    chk(tag, 32'(y), 32'(e));
    cyc();
  endtask

  task automatic run_seq(input string tag, input int n, input logic [31:0] xs,
                         input logic [31:0] ys);
    for (int i = n - 1; i >= 0; i--) begin
      bit_step(tag, xs[i], ys[i]);
    end
  endtask

  task automatic launch(input logic [2:0] len, input logic [1:0] mode,
                        input logic [CNT_W-1:0] tgt);
    cfg_len = len; cfg_mode = mode; cfg_target = tgt;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("launch_busy", 32'(busy), 32'd1);
    chk("launch_cnt_clear", 32'(match_cnt), 32'd0);
  endtask

  task automatic do_abort();
    abort = 1'b1; x = 1'b0;
    cyc();
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; x = 1'b0;
    cfg_len = 3'd0; cfg_mode = 2'd0; cfg_target = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    rst = 1'b1;
    cyc();
    x = 1'b1; #1;
    chk("idle_y", 32'(y), 32'd0);
    cyc();

    // N=3 both polarities: 0000 11111111 0000
    launch(3'd3, 2'b10, '0);
    run_seq("both_y", 16, 32'b0000111111110000, 32'b0011001111110011);
    chk("both_cnt", 32'(match_cnt), 32'd10);
    chk("both_busy", 32'(busy), 32'd1);
    do_abort();

    // N=3 ones only, same data
    launch(3'd3, 2'b00, '0);
    run_seq("ones_y", 16, 32'b0000111111110000, 32'b0000001111110000);
    chk("ones_cnt", 32'(match_cnt), 32'd6);
    do_abort();

    // N=2 ones, target 3
    launch(3'd2, 2'b00, 8'd3);
    run_seq("tgt_y", 4, 32'b1111, 32'b0111);
    chk("tgt_done", 32'(done), 32'd1);
    chk("tgt_busy", 32'(busy), 32'd0);
    chk("tgt_cnt", 32'(match_cnt), 32'd3);
    x = 1'b1; #1;
    chk("done_y", 32'(y), 32'd0);
    cyc();
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_cnt", 32'(match_cnt), 32'd3);

    // no match across a polarity change
    launch(3'd3, 2'b10, '0);
    run_seq("bound_y", 9, 32'b110011100, 32'b000000100);
    chk("bound_cnt", 32'(match_cnt), 32'd1);
    do_abort();

    // cfg_len=0 treated as 2, zeros only
    launch(3'd0, 2'b01, '0);
    run_seq("len0_y", 4, 32'b0010, 32'b0100);
    chk("len0_cnt", 32'(match_cnt), 32'd1);
    do_abort();

    // abort with match_cnt=2
    launch(3'd2, 2'b00, '0);
    run_seq("abort_y", 3, 32'b111, 32'b011);
    chk("pre_abort_cnt", 32'(match_cnt), 32'd2);
    do_abort();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cnt", 32'(match_cnt), 32'd2);
    cyc();
    chk("abort_done2", 32'(done), 32'd0);

    // asynchronous reset mid-run
    launch(3'd2, 2'b00, '0);
    run_seq("prerst_y", 2, 32'b11, 32'b01);
    x = 1'b1;
    rst = 1'b0;
    #1;
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_cnt", 32'(match_cnt), 32'd0);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_y", 32'(y), 32'd0);

    // cfg change and start during RUN are ignored
    launch(3'd3, 2'b00, '0);
    bit_step("cfg_y", 1'b1, 1'b0);
    cfg_len = 3'd2; cfg_mode = 2'b10; start = 1'b1;
    bit_step("cfg_y", 1'b1, 1'b0);
    start = 1'b0;
    run_seq("cfg_y", 2, 32'b11, 32'b11);
    chk("cfg_cnt", 32'(match_cnt), 32'd2);
    chk("cfg_busy", 32'(busy), 32'd1);
    do_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/run_det_ctrl.md
RUN_DET_CTRL -- requirements
Module: run_det_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, the width of the match counter and target.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, a pulse that launches a detection run when IDLE.
REQ-005 SHALL have port abort, input, 1, which terminates a run in progress.
REQ-006 SHALL have port cfg_len, input, 3, the run length N; values 0 and 1 are treated as 2.
REQ-007 SHALL have port cfg_mode, input, 2, the pattern select: 00 ones only, 01 zeros only, 10/11 ones or zeros.
REQ-008 SHALL have port cfg_target, input, CNT_W, the number of matches that ends a run; 0 means unlimited.
REQ-009 SHALL have port x, input, 1, the serial data bit, one per clock.
REQ-010 SHALL have port y, output, 1, the Mealy detect flag: combinational from x and registered state.
REQ-011 SHALL have port busy, output, 1, high in RUN.
REQ-012 SHALL have port done, output, 1, a one-cycle pulse in DONE.
REQ-013 SHALL have port match_cnt, output, CNT_W, the registered count of y cycles in the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE, start=1 SHALL latch cfg_len/cfg_mode/cfg_target into shadow registers, clear match_cnt, run length rl and last bit lb, and enter RUN at the next edge.
REQ-016 cfg_* changes while in RUN or DONE SHALL have no effect; start in RUN or DONE SHALL be ignored.
REQ-017 In RUN, each cycle: rl_next = min(rl+1, N) if rl!=0 and x==lb, else 1; lb_next = x.
REQ-018 y SHALL be 1 iff state==RUN, rl_next==N, and x is enabled by mode (ones: x=1; zeros: x=0; both: either).
REQ-019 Detection SHALL overlap: rl saturates at N, so every further equal bit re-asserts y.
REQ-020 The first bit after entering RUN has no predecessor (rl=0) and SHALL never assert y.
REQ-021 match_cnt SHALL increment by 1 on every RUN cycle with y=1 and saturate at all-ones.
REQ-022 If target!=0 and y=1 with match_cnt+1==target, the FSM SHALL enter DONE at that edge; match_cnt shows target.
REQ-023 abort=1 in RUN SHALL return the FSM to IDLE at the next edge, take priority over REQ-022, not pulse done, and hold match_cnt.
REQ-024 DONE SHALL last exactly one cycle (done=1, busy=0, y=0), then go to IDLE.
REQ-025 match_cnt SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-026 y SHALL be 0 in IDLE and DONE regardless of x.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE, rl=0, lb=0, match_cnt=0, busy=0, done=0 and y=0, without waiting for a clock edge.
REQ-028 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.

Verification
REQ-029 Bench: N=3, mode=10, target=0, x=0000 11111111 0000 -> y high on zeros 3-4, ones 3-8 and zeros 3-4; match_cnt=10.
REQ-030 Bench: N=3, mode=00, same x -> y only on ones 3-8; match_cnt=6.
REQ-031 Bench: N=2, mode=00, target=3, x=1111 -> y on bits 2, 3 and 4; DONE one cycle after bit 4 with done=1 and match_cnt=3; then IDLE.
REQ-032 Bench: N=3, mode=10, x=110011100 -> y only on the third 1; no match across the 1->0 boundary; match_cnt=1.
REQ-033 Bench: RUN with match_cnt=2, abort=1 -> IDLE next edge, done stays 0, match_cnt=2; rst low mid-run -> all outputs 0 asynchronously.
REQ-034 Bench: change cfg_len 3->2 mid-run and pulse start in RUN -> detection still uses N=3 and the run is not restarted.
